// File: rtl/line_request_scheduler.sv
// Three-way scheduler that shares one cacheline adaptor port between the D-cache,
// the I-cache and a next-line prefetcher. Priority is D > I > P, with an age counter guarding I.
module line_request_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int LINE_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  p_read,
  input  logic [ADDR_WIDTH-1:0] p_addr,
  output logic [LINE_WIDTH-1:0] p_rdata,
  output logic                  p_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {NONE, GNT_D, GNT_I, GNT_P} grant_t;

  state_t                state, state_next;
  grant_t                grant, grant_next, winner;
  logic [3:0]            age, age_next;
  logic                  op_write, op_write_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [LINE_WIDTH-1:0] wdata_next;

  assign d_rdata = mem_rdata;
  assign i_rdata = mem_rdata;
  assign p_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= NONE;
      age         <= '0;
      op_write    <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      age         <= age_next;
      op_write    <= op_write_next;
      mem_address <= addr_next;
      mem_wdata   <= wdata_next;
    end
  end

  always_comb begin
    state_next    = state;
    grant_next    = grant;
    age_next      = age;
    op_write_next = op_write;
    addr_next     = mem_address;
    wdata_next    = mem_wdata;
    winner        = NONE;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    d_resp        = 1'b0;
    i_resp        = 1'b0;
    p_resp        = 1'b0;
    case (state)
      IDLE: begin
        // An I request that has waited out STARVE_LIMIT D grants jumps the queue.
        if (i_read && age == 4'(STARVE_LIMIT)) winner = GNT_I;
        else if (d_read || d_write)            winner = GNT_D;
        else if (i_read)                       winner = GNT_I;
        else if (p_read)                       winner = GNT_P;
        if (winner != NONE) begin
          state_next = BUSY;
          grant_next = winner;
          case (winner)
            GNT_D: begin
              addr_next     = d_addr;
              op_write_next = d_write;
              if (d_write) wdata_next = d_wdata;
            end
            GNT_I: begin
              addr_next     = i_addr;
              op_write_next = 1'b0;
            end
            default: begin
              addr_next     = p_addr;
              op_write_next = 1'b0;
            end
          endcase
          if (winner == GNT_D && i_read) age_next = (age == 4'hF) ? age : age + 4'd1;
          else                           age_next = '0;
        end
      end
      default: begin
        mem_read  = !op_write;
        mem_write = op_write;
        // Completion always returns to IDLE so a requester's dropped request is never re-granted.
        if (mem_resp) begin
          d_resp     = (grant == GNT_D);
          i_resp     = (grant == GNT_I);
          p_resp     = (grant == GNT_P);
          state_next = IDLE;
          grant_next = NONE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_line_request_scheduler.sv
// Directed self-checking bench for line_request_scheduler; the bench plays the
// cacheline adaptor and all three requesters.
module tb_line_request_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         d_read = 1'b0, d_write = 1'b0;
  logic [31:0]  d_addr = '0;
  logic [255:0] d_wdata = '0, d_rdata;
  logic         d_resp;
  logic         i_read = 1'b0;
  logic [31:0]  i_addr = '0;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         p_read = 1'b0;
  logic [31:0]  p_addr = '0;
  logic [255:0] p_rdata;
  logic         p_resp;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_resp = 1'b0;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_W  = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] PAT_3C = {32{8'h3C}};
  localparam logic [255:0] PAT_5A = {32{8'h5A}};

  line_request_scheduler #(.STARVE_LIMIT(4), .LINE_WIDTH(256), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .p_read(p_read), .p_addr(p_addr), .p_rdata(p_rdata), .p_resp(p_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic dr, input logic dw, input logic [31:0] da,
                               input logic ir, input logic [31:0] ia,
                               input logic pr, input logic [31:0] pa);
    d_read = dr; d_write = dw; d_addr = da;
    i_read = ir; i_addr = ia;
    p_read = pr; p_addr = pa;
  endtask

  // Adaptor model: called in BUSY cycle 1, completes in BUSY cycle 'delay'.
  task automatic serve(input string tag, input int delay, input logic [255:0] data,
                       input logic [2:0] exp_resp, input logic is_read);
    for (int k = 1; k < delay; k++) begin
      tick();
      checkOutput({tag, "_noresp"}, {253'b0, d_resp, i_resp, p_resp}, 256'b0);
    end
    mem_resp  = 1'b1;
    mem_rdata = data;
    #1;
    checkOutput({tag, "_resp"}, {253'b0, d_resp, i_resp, p_resp}, {253'b0, exp_resp});
    if (is_read) begin
      if (exp_resp[2]) checkOutput({tag, "_d_rdata"}, d_rdata, data);
      if (exp_resp[1]) checkOutput({tag, "_i_rdata"}, i_rdata, data);
      if (exp_resp[0]) checkOutput({tag, "_p_rdata"}, p_rdata, data);
    end
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic checkIdle(input string tag);
    #1;
    checkOutput({tag, "_idle_req"}, {254'b0, mem_read, mem_write}, 256'b0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_req", {254'b0, mem_read, mem_write}, 256'b0);
    checkOutput("rst_resp", {253'b0, d_resp, i_resp, p_resp}, 256'b0);
    checkOutput("rst_addr", {224'b0, mem_address}, 256'b0);
    checkOutput("rst_wdata", mem_wdata, 256'b0);

    // Single I read
    applyStimulus(0, 0, 0, 1, 32'h0000_0060, 0, 0);
    #1;
    checkOutput("t1_idle_read", {255'b0, mem_read}, 256'b0);
    tick();
    checkOutput("t1_mem_read", {255'b0, mem_read}, 256'd1);
    checkOutput("t1_addr", {224'b0, mem_address}, 256'h60);
    serve("t1", 4, PAT_A5, 3'b010, 1'b1);
    i_read = 1'b0;
    checkIdle("t1");

    // D write racing an I read
    d_wdata = PAT_W;
    applyStimulus(0, 1, 32'h0000_1000, 1, 32'h0000_0200, 0, 0);
    tick();
    checkOutput("t2_mem_write", {254'b0, mem_read, mem_write}, 256'b01);
    checkOutput("t2_addr", {224'b0, mem_address}, 256'h1000);
    checkOutput("t2_wdata", mem_wdata, PAT_W);
    serve("t2", 2, '0, 3'b100, 1'b0);
    d_write = 1'b0;
    checkIdle("t2");
    tick();
    checkOutput("t2_i_read", {254'b0, mem_read, mem_write}, 256'b10);
    checkOutput("t2_i_addr", {224'b0, mem_address}, 256'h200);
    checkOutput("t2_age", {252'b0, dut.age}, 256'd0);
    serve("t2i", 1, PAT_3C, 3'b010, 1'b1);
    i_read = 1'b0;
    checkIdle("t2i");

    // Starvation: four D grants, then I
    applyStimulus(1, 0, 32'h0000_2000, 1, 32'h0000_0300, 0, 0);
    for (int g = 0; g < 4; g++) begin
      tick();
      checkOutput($sformatf("t3_d%0d_addr", g), {224'b0, mem_address}, 256'h2000);
      checkOutput($sformatf("t3_d%0d_age", g), {252'b0, dut.age}, 256'(g + 1));
      serve($sformatf("t3_d%0d", g), 1, PAT_5A, 3'b100, 1'b1);
      checkIdle($sformatf("t3_d%0d", g));
    end
    tick();
    checkOutput("t3_i_addr", {224'b0, mem_address}, 256'h300);
    checkOutput("t3_i_age", {252'b0, dut.age}, 256'd0);
    serve("t3i", 2, PAT_A5, 3'b010, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkIdle("t3i");

    // Prefetch loses to D, served afterwards
    applyStimulus(1, 0, 32'h0000_0500, 0, 0, 1, 32'h0000_0400);
    tick();
    checkOutput("t4_d_addr", {224'b0, mem_address}, 256'h500);
    serve("t4d", 2, PAT_3C, 3'b100, 1'b1);
    d_read = 1'b0;
    checkIdle("t4d");
    tick();
    checkOutput("t4_p_addr", {224'b0, mem_address}, 256'h400);
    checkOutput("t4_p_read", {255'b0, mem_read}, 256'd1);
    serve("t4p", 3, PAT_5A, 3'b001, 1'b1);
    p_read = 1'b0;
    checkIdle("t4p");

    // Reset two cycles into a D read
    applyStimulus(1, 0, 32'h0000_0600, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("t5_req", {254'b0, mem_read, mem_write}, 256'b0);
    checkOutput("t5_resp", {253'b0, d_resp, i_resp, p_resp}, 256'b0);
    checkOutput("t5_addr", {224'b0, mem_address}, 256'h0);
    tick();
    checkOutput("t5_regrant", {224'b0, mem_address}, 256'h600);
    serve("t5", 1, PAT_A5, 3'b100, 1'b1);
    d_read = 1'b0;
    checkIdle("t5");

    // Spurious mem_resp in IDLE, then d_addr changed mid-BUSY
    mem_resp = 1'b1;
    #1;
    checkOutput("t6_spur_resp", {253'b0, d_resp, i_resp, p_resp}, 256'b0);
    tick();
    mem_resp = 1'b0;
    #1;
    checkOutput("t6_spur_idle", {254'b0, mem_read, mem_write}, 256'b0);
    applyStimulus(1, 0, 32'h0000_0700, 0, 0, 0, 0);
    tick();
    d_addr = 32'h0000_07FF;
    #1;
    checkOutput("t6_addr_hold0", {224'b0, mem_address}, 256'h700);
    tick();
    checkOutput("t6_addr_hold1", {224'b0, mem_address}, 256'h700);
    serve("t6", 1, PAT_3C, 3'b100, 1'b1);
    d_read = 1'b0;
    checkIdle("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
